// File: rtl/drum_mul_sched.sv
// drum_mul_sched: round-robin scheduler that shares one approximate DRUM6
// signed multiplier among NREQ requesters through a two-stage pipeline.
module drum_mul_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_x,
  input  logic [NREQ*32-1:0] req_y,
  input  logic [NREQ-1:0]   cfg_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_p,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy,
  output logic [31:0]       acc_cnt
);

  // Unsigned 32x32 DRUM6 core: each operand is reduced to the six bits starting
  // at its leading one (LSB forced to 1 to unbias), then the short product is
  // shifted back. Operands below 64 pass through untouched, so small products
  // are exact.
  function automatic logic [63:0] drum6(input logic [31:0] a, input logic [31:0] b);
    logic [4:0]  lead_a, lead_b, sh_a, sh_b;
    logic [5:0]  t_a, t_b;
    logic [11:0] prod;
    lead_a = '0;
    lead_b = '0;
    for (int i = 0; i < 32; i++) begin
      if (a[i]) lead_a = i[4:0];
      if (b[i]) lead_b = i[4:0];
    end
    if (lead_a >= 5'd6) begin
      sh_a = lead_a - 5'd5;
      t_a  = 6'(a >> sh_a) | 6'd1;
    end else begin
      sh_a = '0;
      t_a  = a[5:0];
    end
    if (lead_b >= 5'd6) begin
      sh_b = lead_b - 5'd5;
      t_b  = 6'(b >> sh_b) | 6'd1;
    end else begin
      sh_b = '0;
      t_b  = b[5:0];
    end
    prod = {6'd0, t_a} * {6'd0, t_b};
    return {52'd0, prod} << ({1'b0, sh_a} + {1'b0, sh_b});
  endfunction

  // Pipeline and scheduler state
  logic            s1_valid_q, s1_valid_d;
  logic [31:0]     s1_mx_q, s1_mx_d;
  logic [31:0]     s1_my_q, s1_my_d;
  logic            s1_sign_q, s1_sign_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            s2_valid_q, s2_valid_d;
  logic [63:0]     s2_p_q, s2_p_d;
  logic [IDW-1:0]  s2_id_q, s2_id_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [31:0]     acc_cnt_q, acc_cnt_d;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic            adv;
  logic            s1_load;
  logic            accept;
  logic [31:0]     sel_x, sel_y;
  logic [63:0]     core_p;

  assign eligible = req_valid & cfg_mask;
  assign adv      = !s2_valid_q || rsp_ready;
  assign s1_load  = adv || !s1_valid_q;
  assign accept   = grant_any && s1_load;

  // Round-robin search: first eligible requester at or after rr_ptr, wrapping.
  // NOTE: every always_comb output gets a default on entry so no path leaves it unassigned (no latch).
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      int idx;
      idx = int'(rr_ptr_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_any && eligible[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

  // Next-state for both stages, pointer and counter; everything holds by default.
  always_comb begin
    sel_x      = req_x[int'(grant_idx)*32 +: 32];
    sel_y      = req_y[int'(grant_idx)*32 +: 32];
    core_p     = drum6(s1_mx_q, s1_my_q);
    s1_valid_d = s1_valid_q;
    s1_mx_d    = s1_mx_q;
    s1_my_d    = s1_my_q;
    s1_sign_d  = s1_sign_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_p_d     = s2_p_q;
    s2_id_d    = s2_id_q;
    rr_ptr_d   = rr_ptr_q;
    acc_cnt_d  = acc_cnt_q;
    if (adv) begin
      s2_valid_d = s1_valid_q;
      s2_p_d     = s1_sign_q ? (64'd0 - core_p) : core_p;
      s2_id_d    = s1_id_q;
    end
    if (s1_load) begin
      s1_valid_d = grant_any;
      s1_mx_d    = sel_x[31] ? (~sel_x + 32'd1) : sel_x;
      s1_my_d    = sel_y[31] ? (~sel_y + 32'd1) : sel_y;
      s1_sign_d  = sel_x[31] ^ sel_y[31];
      s1_id_d    = grant_idx;
    end
    if (accept) begin
      rr_ptr_d  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      acc_cnt_d = acc_cnt_q + 32'd1;
    end
  end

  // State registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  // NOTE: the datapath registers are reset as well so rsp_p/rsp_id read 0 after reset, not stale data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mx_q    <= '0;
      s1_my_q    <= '0;
      s1_sign_q  <= 1'b0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_p_q     <= '0;
      s2_id_q    <= '0;
      rr_ptr_q   <= '0;
      acc_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mx_q    <= s1_mx_d;
      s1_my_q    <= s1_my_d;
      s1_sign_q  <= s1_sign_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_p_q     <= s2_p_d;
      s2_id_q    <= s2_id_d;
      rr_ptr_q   <= rr_ptr_d;
      acc_cnt_q  <= acc_cnt_d;
    end
  end

  // Outputs are forced quiet while reset is asserted, even before the edge.
  always_comb begin
    req_ready = rst_n ? (grant & {NREQ{s1_load}}) : '0;
    rsp_valid = rst_n && s2_valid_q;
    rsp_p     = rst_n ? s2_p_q : '0;
    rsp_id    = rst_n ? s2_id_q : '0;
    busy      = rst_n && (s1_valid_q || s2_valid_q);
    acc_cnt   = acc_cnt_q;
  end

endmodule
